// File: rtl/seg_scan_driver_if.sv
// Bundle of the display-driver signals between producer logic and the scan driver.
// Ports: master drives Load/Value/DP/Lz_en; slave (the driver) returns Seg/Dp_out/An/Frame.
// Latency: n/a (wires only). Backpressure: none; Load is fire-and-forget.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   Value;
  logic [DIGITS-1:0]     DP;
  logic                  Lz_en;
  logic [6:0]            Seg;
  logic                  Dp_out;
  logic [DIGITS-1:0]     An;
  logic                  Frame;

  modport master (
    output Load, Value, DP, Lz_en,
    input  Seg, Dp_out, An, Frame
  );

  modport slave (
    input  Load, Value, DP, Lz_en,
    output Seg, Dp_out, An, Frame
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-synchronous (tear-free) value updates.
// Ports: clk, rst (sync, active-high), bus (slave modport: Load/Value/DP/Lz_en in, Seg/Dp_out/An/Frame out).
// Latency: outputs registered, lag the scan index by 1 cycle. Backpressure: none; last Load before a frame boundary wins.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_driver_if.slave  bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [TW-1:0]          tick;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    disp_val;
  logic [DIGITS-1:0]      disp_dp;
  logic [4*DIGITS-1:0]    pend_val;
  logic [DIGITS-1:0]      pend_dp;
  logic                   pend;
  // Set on the boundary edge that swapped the display; becomes Frame one edge
  // later so the pulse coincides with the first output cycle of the new frame.
  logic                   upd;

  logic                   boundary;
  logic [3:0]             cur_nib;
  logic                   hi_zero;
  logic                   blank;
  logic [6:0]             seg_l;
  logic [DIGITS-1:0]      an_l;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  assign boundary = (tick == TICK_LAST) && (idx == IDX_LAST);
  assign cur_nib  = disp_val[idx*4 +: 4];

  // The current digit and every more-significant digit are zero.
  always_comb begin
    hi_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && (disp_val[4*j +: 4] != 4'h0)) hi_zero = 1'b0;
    end
  end

  // Digit 0 is never blanked so a zero value still shows "0".
  assign blank = bus.Lz_en && (idx != '0) && hi_zero;
  assign seg_l = blank ? 7'b0000000 : hex7(cur_nib);
  assign an_l  = DIGITS'(1) << idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick       <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
      upd        <= 1'b0;
      bus.Seg    <= {7{SEG_ACTIVE_LOW}};
      bus.Dp_out <= SEG_ACTIVE_LOW;
      bus.An     <= {DIGITS{AN_ACTIVE_LOW}};
      bus.Frame  <= 1'b0;
    end else begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        tick <= tick + TW'(1);
      end

      upd <= 1'b0;
      if (boundary) begin
        // A Load on the boundary itself is newer than anything pending.
        if (bus.Load) begin
          disp_val <= bus.Value;
          disp_dp  <= bus.DP;
          pend     <= 1'b0;
          upd      <= 1'b1;
        end else if (pend) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
          pend     <= 1'b0;
          upd      <= 1'b1;
        end
      end else if (bus.Load) begin
        pend_val <= bus.Value;
        pend_dp  <= bus.DP;
        pend     <= 1'b1;
      end

      bus.Seg    <= seg_l ^ {7{SEG_ACTIVE_LOW}};
      bus.Dp_out <= disp_dp[idx] ^ SEG_ACTIVE_LOW;
      bus.An     <= an_l ^ {DIGITS{AN_ACTIVE_LOW}};
      bus.Frame  <= upd;
    end
  end

endmodule
